// File: rtl/mem_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake states, arbiter FSM
// states, default widths and the word type.
package mem_types_pkg;

    localparam int DEF_WORD_W     = 32;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DGNT = 2'd1,
        IGNT = 2'd2
    } arb_state_t;

    typedef logic [DEF_WORD_W-1:0] word_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the dcache and icache control units.
// Grants one side at a time, keeps the dcache locked in across burst words,
// and forces the icache in after STARVE_MAX dcache words while it waits.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; RAM strobes low, both sides stalled
// DGNT  | dcache owns the RAM port; completes a word on ramstate ACCESS
// IGNT  | icache owns the RAM port; completes a word on ramstate ACCESS
module mem_arbiter
    import mem_types_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int WORD_W     = DEF_WORD_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ram_err
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t       state, next_state;
    logic [CNT_W-1:0] starve_cnt, starve_cnt_next;
    ramstate_t        rs;
    logic             dreq, access, d_done, i_done;
    logic             starve_full, starve_trip;

    assign rs     = ramstate_t'(ramstate);
    assign dreq   = dREN | dWEN;
    assign access = (rs == ACCESS);
    // A word only completes while its requester is still asking; a dropped
    // request in the same cycle as ACCESS is treated as an abort.
    assign d_done = (state == DGNT) & dreq & access;
    assign i_done = (state == IGNT) & iREN & access;

    assign starve_full = (starve_cnt == CNT_W'(STARVE_MAX));
    // Looks one word ahead so the grant flips right after the word that
    // reaches the limit, rather than one word later.
    assign starve_trip = ((32'(starve_cnt) + 32'd1) >= 32'(STARVE_MAX));

    // Read data is passed straight through; the wait lines qualify it.
    assign iload = ramload;
    assign dload = ramload;

    // State and starvation counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= next_state;
            starve_cnt <= starve_cnt_next;
        end
    end

    // Next-state selection and starvation counter update.
    always_comb begin
        next_state      = state;
        starve_cnt_next = starve_cnt;

        case (state)
            IDLE: begin
                if (dreq && !(iREN && starve_full))
                    next_state = DGNT;
                else if (iREN)
                    next_state = IGNT;
            end
            DGNT: begin
                if (!dreq)
                    next_state = IDLE;
                else if (access) begin
                    if (iREN && starve_trip)
                        next_state = IGNT;
                    else
                        next_state = DGNT;
                end
            end
            IGNT: begin
                if (!iREN)
                    next_state = IDLE;
                else if (access)
                    next_state = dreq ? DGNT : IGNT;
            end
            default: next_state = IDLE;
        endcase

        if (!iREN || i_done)
            starve_cnt_next = '0;
        else if (d_done && !starve_full)
            starve_cnt_next = starve_cnt + CNT_W'(1);
    end

    // RAM strobes, address/data mux and per-side wait decode.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        ram_err  = 1'b0;

        case (state)
            DGNT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~d_done;
                ram_err  = (rs == ERROR);
            end
            IGNT: begin
                ramREN   = iREN;
                ramaddr  = iaddr;
                iwait    = ~i_done;
                ram_err  = (rs == ERROR);
            end
            default: ;
        endcase

        if (RST) begin
            ramREN = 1'b0;
            ramWEN = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (starvation limits 4 and 2) share one
// stimulus stream and are compared every cycle against a port-ownership model.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;

    logic        a_iwait, a_dwait, a_ramREN, a_ramWEN, a_ram_err;
    logic [31:0] a_iload, a_dload, a_ramaddr, a_ramstore;
    logic        b_iwait, b_dwait, b_ramREN, b_ramWEN, b_ram_err;
    logic [31:0] b_iload, b_dload, b_ramaddr, b_ramstore;

    int checks = 0;
    int errors = 0;

    // Model: who holds the RAM port (0 none, 1 dcache, 2 icache) and how
    // many dcache words have finished while the icache has been waiting.
    int owner [2];
    int waited[2];
    int limit [2] = '{4, 2};

    always #5 CLK = ~CLK;

    mem_arbiter #(.STARVE_MAX(4), .WORD_W(32)) dut_a (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(a_iwait), .iload(a_iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(a_dwait), .dload(a_dload),
        .ramREN(a_ramREN), .ramWEN(a_ramWEN), .ramaddr(a_ramaddr),
        .ramstore(a_ramstore), .ramload(ramload), .ramstate(ramstate),
        .ram_err(a_ram_err)
    );

    mem_arbiter #(.STARVE_MAX(2), .WORD_W(32)) dut_b (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(b_iwait), .iload(b_iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(b_dwait), .dload(b_dload),
        .ramREN(b_ramREN), .ramWEN(b_ramWEN), .ramaddr(b_ramaddr),
        .ramstore(b_ramstore), .ramload(ramload), .ramstate(ramstate),
        .ram_err(b_ram_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare one instance against what the model says the port should show.
    task automatic compare_inst(input int k);
        logic        rr, rw, iw, dw, re;
        logic [31:0] ra, rst_data;
        logic        o_rr, o_rw, o_iw, o_dw, o_re;
        logic [31:0] o_ra, o_rs, o_il, o_dl;
        string       p;
        bit          dreq, acc;
        dreq = dREN | dWEN;
        acc  = (ramstate == 2'd2);
        rr = 0; rw = 0; ra = 0; rst_data = 0; iw = 1; dw = 1; re = 0;
        if (owner[k] == 1) begin
            rw = dWEN; rr = dREN && !dWEN; ra = daddr; rst_data = dstore;
            dw = !(acc && dreq); re = (ramstate == 2'd3);
        end else if (owner[k] == 2) begin
            rr = iREN; ra = iaddr;
            iw = !(acc && iREN); re = (ramstate == 2'd3);
        end
        if (RST) begin rr = 0; rw = 0; end
        if (k == 0) begin
            p = "a";
            o_rr = a_ramREN; o_rw = a_ramWEN; o_ra = a_ramaddr; o_rs = a_ramstore;
            o_iw = a_iwait; o_dw = a_dwait; o_re = a_ram_err; o_il = a_iload; o_dl = a_dload;
        end else begin
            p = "b";
            o_rr = b_ramREN; o_rw = b_ramWEN; o_ra = b_ramaddr; o_rs = b_ramstore;
            o_iw = b_iwait; o_dw = b_dwait; o_re = b_ram_err; o_il = b_iload; o_dl = b_dload;
        end
        chk({p, ".ramREN"},   {31'd0, o_rr}, {31'd0, rr});
        chk({p, ".ramWEN"},   {31'd0, o_rw}, {31'd0, rw});
        chk({p, ".ramaddr"},  o_ra, ra);
        chk({p, ".ramstore"}, o_rs, rst_data);
        chk({p, ".iwait"},    {31'd0, o_iw}, {31'd0, iw});
        chk({p, ".dwait"},    {31'd0, o_dw}, {31'd0, dw});
        chk({p, ".ram_err"},  {31'd0, o_re}, {31'd0, re});
        chk({p, ".iload"},    o_il, ramload);
        chk({p, ".dload"},    o_dl, ramload);
    endtask

    // Advance the ownership model across one rising edge.
    task automatic model_edge(input int k);
        bit dreq, acc, done;
        int nxt;
        dreq = dREN | dWEN;
        acc  = (ramstate == 2'd2);
        if (RST) begin
            owner[k] = 0; waited[k] = 0;
            return;
        end
        done = (owner[k] == 1 && dreq && acc) || (owner[k] == 2 && iREN && acc);
        nxt  = owner[k];
        case (owner[k])
            0: if (dreq && !(iREN && waited[k] == limit[k])) nxt = 1;
               else if (iREN) nxt = 2;
            1: if (!dreq) nxt = 0;
               else if (done) nxt = (iREN && waited[k] + 1 >= limit[k]) ? 2 : 1;
            default: if (!iREN) nxt = 0;
                     else if (done) nxt = dreq ? 1 : 2;
        endcase
        if (!iREN || (owner[k] == 2 && done)) waited[k] = 0;
        else if (owner[k] == 1 && done && waited[k] < limit[k]) waited[k] = waited[k] + 1;
        owner[k] = nxt;
    endtask

    task automatic step();
        @(negedge CLK);
        compare_inst(0);
        compare_inst(1);
        @(posedge CLK);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0; ramstate = 2'd0;
    endtask

    initial begin
        RST = 1; idle_inputs();
        iaddr = 0; daddr = 0; dstore = 0; ramload = 32'h0BAD_F00D;
        @(posedge CLK);
        model_edge(0); model_edge(1);
        #1;

        // Reset held with a pending dcache read.
        dREN = 1; daddr = 32'h10;
        step();
        chk("rst.ramREN", {31'd0, a_ramREN}, 32'd0);
        chk("rst.dwait",  {31'd0, a_dwait},  32'd1);
        step();
        RST = 0;
        step();
        #1;
        chk("rst.release_ramREN", {31'd0, a_ramREN}, 32'd1);
        dREN = 0;
        step();

        // Single icache read, data on the second grant cycle.
        iREN = 1; iaddr = 32'h40;
        step();
        ramstate = 2'd1;
        step();
        ramstate = 2'd2; ramload = 32'hCAFE_0001;
        #1;
        chk("iread.iwait", {31'd0, a_iwait}, 32'd0);
        chk("iread.iload", a_iload, 32'hCAFE_0001);
        chk("iread.addr",  a_ramaddr, 32'h40);
        step();
        iREN = 0; ramstate = 2'd0;
        step();
        step();

        // Dcache 4-word burst with icache waiting.
        iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h100; dstore = 32'h1111;
        step();
        for (int w = 0; w < 4; w++) begin
            dWEN = (w < 2); dREN = (w >= 2);
            daddr = 32'h100 + 32'(w * 4); dstore = 32'h1111 * 32'(w + 1);
            ramstate = 2'd2; ramload = 32'hD000 + 32'(w);
            #1;
            chk("burst.addr",  a_ramaddr, daddr);
            chk("burst.dwait", {31'd0, a_dwait}, 32'd0);
            step();
        end
        dREN = 0; dWEN = 0; ramstate = 2'd0;
        #1;
        chk("burst.then_iaddr", a_ramaddr, 32'h80);
        chk("burst.then_iREN",  {31'd0, a_ramREN}, 32'd1);
        step();
        ramstate = 2'd2;
        step();
        idle_inputs();
        step();
        step();

        // Starvation on the limit-2 instance.
        dREN = 1; daddr = 32'h300; iREN = 1; iaddr = 32'h44;
        step();
        ramstate = 2'd2;
        step();
        step();
        ramstate = 2'd1;
        #1;
        chk("starve.igrant_addr", b_ramaddr, 32'h44);
        chk("starve.dwait",       {31'd0, b_dwait}, 32'd1);
        step();
        ramstate = 2'd2;
        #1;
        chk("starve.iwait", {31'd0, b_iwait}, 32'd0);
        chk("starve.dwait_hold", {31'd0, b_dwait}, 32'd1);
        step();
        ramstate = 2'd0;
        #1;
        chk("starve.back_to_d", b_ramaddr, 32'h300);
        idle_inputs();
        step();
        step();

        // Same-cycle contention, then ERROR cycles and a write abort.
        iREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'h1234_5678;
        step();
        #1;
        chk("cont.ramWEN",   {31'd0, a_ramWEN}, 32'd1);
        chk("cont.ramaddr",  a_ramaddr, 32'h200);
        chk("cont.ramstore", a_ramstore, 32'h1234_5678);
        ramstate = 2'd3;
        for (int e = 0; e < 3; e++) begin
            #1;
            chk("err.pulse", {31'd0, a_ram_err}, 32'd1);
            chk("err.dwait", {31'd0, a_dwait},   32'd1);
            step();
        end
        dWEN = 0; iREN = 0; ramstate = 2'd0;
        step();
        #1;
        chk("abort.ramWEN", {31'd0, a_ramWEN}, 32'd0);
        chk("abort.ramREN", {31'd0, a_ramREN}, 32'd0);
        step();

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            int r;
            if ($urandom_range(3) == 0) iREN = ~iREN;
            if ($urandom_range(3) == 0) dREN = ~dREN;
            if ($urandom_range(5) == 0) dWEN = ~dWEN;
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            r = int'($urandom_range(9));
            ramstate = (r < 4) ? 2'd2 : (r < 7) ? 2'd1 : (r < 9) ? 2'd0 : 2'd3;
            RST = ($urandom_range(99) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
